// File: rtl/signal_buffer_writer.sv
// Writer side of the shared ECG/EMG display memory: arbitrates two 12-bit sample
// streams into per-channel frame windows, then commits per-frame min/max scaling words.
module signal_buffer_writer #(
    parameter int ADDR_WIDTH   = 12,
    parameter int SAMPLE_WIDTH = 12,
    parameter int DEPTH        = 320,
    parameter logic [ADDR_WIDTH-1:0] ECG_BASE  = 12'h559,
    parameter logic [ADDR_WIDTH-1:0] EMG_BASE  = 12'h6AD,
    parameter logic [ADDR_WIDTH-1:0] STAT_BASE = 12'd1705
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    ecg_valid,
    input  logic [SAMPLE_WIDTH-1:0] ecg_data,
    output logic                    ecg_ready,
    input  logic                    emg_valid,
    input  logic [SAMPLE_WIDTH-1:0] emg_data,
    output logic                    emg_ready,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [31:0]             mem_data,
    output logic                    mem_wEn,
    output logic                    frame_done,
    output logic                    busy
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0]        LAST  = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0]        I_ONE = IDX_W'(1);
    localparam logic [SAMPLE_WIDTH-1:0] S_MAX = '1;
    localparam logic [SAMPLE_WIDTH-1:0] S_ONE = SAMPLE_WIDTH'(1);

    typedef enum logic [2:0] {RUN, STAT0, STAT1, STAT2, STAT3} state_t;

    state_t                             state;
    logic [1:0][IDX_W-1:0]              idx;
    logic [1:0]                         full;
    logic [1:0][SAMPLE_WIDTH-1:0]       mn, mx, mn_w, mx_w, smp;
    logic [1:0][ADDR_WIDTH-1:0]         base;
    logic [1:0]                         valid, req, acc;
    logic                               prio, run, contest, ch, done_pend;
    logic [SAMPLE_WIDTH-1:0]            sample;

    // Channel 0 is ECG, channel 1 is EMG; prio=0 favours ECG on the next contest.
    assign run     = (state == RUN);
    assign valid   = {emg_valid, ecg_valid};
    assign smp     = {emg_data, ecg_data};
    assign base    = {EMG_BASE, ECG_BASE};
    assign req     = valid & ~full;
    assign contest = run & (&req);

    assign ecg_ready = run & ~full[0] & (~req[1] | ~prio);
    assign emg_ready = run & ~full[1] & (~req[0] | prio);
    assign acc       = valid & {emg_ready, ecg_ready};
    assign ch        = ~acc[0];
    assign sample    = smp[ch];
    assign busy      = ~run;

    // The display divides by (max - min), so a flat frame must still yield a non-zero span.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            mn_w[c] = mn[c];
            mx_w[c] = mx[c];
            if (mx[c] <= mn[c]) begin
                if (mn[c] == S_MAX) begin
                    mn_w[c] = S_MAX - S_ONE;
                    mx_w[c] = S_MAX;
                end else begin
                    mx_w[c] = mn[c] + S_ONE;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= RUN;
            idx        <= '0;
            full       <= '0;
            mn         <= {2{S_MAX}};
            mx         <= '0;
            prio       <= 1'b0;
            mem_wEn    <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            frame_done <= 1'b0;
            done_pend  <= 1'b0;
        end else begin
            mem_wEn    <= 1'b0;
            frame_done <= done_pend;
            done_pend  <= 1'b0;
            case (state)
                RUN: begin
                    if (|acc) begin
                        mem_wEn  <= 1'b1;
                        mem_addr <= base[ch] + ADDR_WIDTH'(idx[ch]);
                        mem_data <= 32'(sample);
                        if (idx[ch] == LAST) begin
                            idx[ch]  <= '0;
                            full[ch] <= 1'b1;
                        end else begin
                            idx[ch] <= idx[ch] + I_ONE;
                        end
                        if (sample < mn[ch]) mn[ch] <= sample;
                        if (sample > mx[ch]) mx[ch] <= sample;
                    end
                    if (contest) prio <= ~prio;
                    if (&full) state <= STAT0;
                end
                STAT0: begin
                    mem_wEn  <= 1'b1;
                    mem_addr <= STAT_BASE;
                    mem_data <= 32'(mn_w[0]);
                    state    <= STAT1;
                end
                STAT1: begin
                    mem_wEn  <= 1'b1;
                    mem_addr <= STAT_BASE + ADDR_WIDTH'(1);
                    mem_data <= 32'(mn_w[1]);
                    state    <= STAT2;
                end
                STAT2: begin
                    mem_wEn  <= 1'b1;
                    mem_addr <= STAT_BASE + ADDR_WIDTH'(2);
                    mem_data <= 32'(mx_w[0]);
                    state    <= STAT3;
                end
                STAT3: begin
                    mem_wEn   <= 1'b1;
                    mem_addr  <= STAT_BASE + ADDR_WIDTH'(3);
                    mem_data  <= 32'(mx_w[1]);
                    full      <= '0;
                    mn        <= {2{S_MAX}};
                    mx        <= '0;
                    done_pend <= 1'b1;
                    state     <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule
